// File: rtl/alu_seq_unit.sv
// Handshaked WIDTH-bit ALU with registered result/flags; iterative shift-add
// multiply and restoring divide are built only when ALU_SEQ_MULDIV_EN is defined.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_LAND = 4'd5;
  localparam logic [3:0] OP_LOR  = 4'd6;
  localparam logic [3:0] OP_LNOT = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_XOR  = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_DEC  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  logic [3:0]       flags_q;

  logic             accept;
  logic [WIDTH-1:0] rhs_d;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   diff_d;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] sc_res_d;
  logic [WIDTH-1:0] sc_hi_d;
  logic             sc_carry;
  logic             sc_ovf;
  logic             sc_dz;
  logic             sc_unsup;
  logic [3:0]       sc_flags_d;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

`ifdef ALU_SEQ_MULDIV_EN
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             start_multi;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] mc_res_d;
  logic [3:0]       mc_flags_d;

  // One iteration: hi:lo is the running product (mul) or remainder:quotient (div/mod).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (op_q == OP_MUL) begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      hi_d = div_trial[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final result and flags once all iterations are done.
  always_comb begin
    mc_res_d = (op_q == OP_MOD) ? hi_q : lo_q;
    if (op_q == OP_MUL) begin
      mc_flags_d = {1'b0, (hi_q != '0), 1'b0, ({hi_q, lo_q} == '0)};
    end else begin
      mc_flags_d = {3'b000, (mc_res_d == '0)};
    end
  end
`endif

  // Single-cycle datapath; inc/dec reuse the add/sub path with a constant 1.
  always_comb begin
    rhs_d    = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
    sum_d    = {1'b0, a} + {1'b0, rhs_d};
    diff_d   = {1'b0, a} - {1'b0, rhs_d};
    add_ovf  = (a[WIDTH-1] == rhs_d[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
    sub_ovf  = (a[WIDTH-1] != rhs_d[WIDTH-1]) && (diff_d[WIDTH-1] != a[WIDTH-1]);
    sc_res_d = '0;
    sc_hi_d  = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    sc_unsup = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    start_multi = 1'b0;
`endif
    case (op)
      OP_ADD, OP_INC: begin
        sc_res_d = sum_d[WIDTH-1:0];
        sc_carry = sum_d[WIDTH];
        sc_ovf   = add_ovf;
      end
      OP_SUB, OP_DEC: begin
        sc_res_d = diff_d[WIDTH-1:0];
        sc_carry = diff_d[WIDTH];
        sc_ovf   = sub_ovf;
      end
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL: start_multi = 1'b1;
      OP_DIV, OP_MOD: begin
        // Zero divisor finishes immediately instead of iterating.
        if (b == '0) begin
          sc_res_d = (op == OP_DIV) ? '1 : a;
          sc_hi_d  = a;
          sc_dz    = 1'b1;
        end else begin
          start_multi = 1'b1;
        end
      end
`else
      OP_MUL, OP_DIV, OP_MOD: sc_unsup = 1'b1;
`endif
      OP_LAND: sc_res_d = WIDTH'((a != '0) && (b != '0));
      OP_LOR:  sc_res_d = WIDTH'((a != '0) || (b != '0));
      OP_LNOT: sc_res_d = WIDTH'(a == '0);
      OP_NOT:  sc_res_d = ~a;
      OP_AND:  sc_res_d = a & b;
      OP_OR:   sc_res_d = a | b;
      OP_XOR:  sc_res_d = a ^ b;
      OP_SHL: begin
        sc_res_d = {a[WIDTH-2:0], 1'b0};
        sc_carry = a[WIDTH-1];
      end
      OP_SHR: begin
        sc_res_d = {1'b0, a[WIDTH-1:1]};
        sc_carry = a[0];
      end
      default: sc_res_d = '0;
    endcase
    sc_flags_d = sc_unsup ? 4'b1000 : {sc_dz, sc_ovf, sc_carry, (sc_res_d == '0)};
  end

  // Control FSM and all result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (start_multi) begin
              state_q <= S_BUSY;
              cnt_q   <= CW'(WIDTH);
              op_q    <= op;
              opnd_q  <= b;
              hi_q    <= '0;
              lo_q    <= a;
            end else
`endif
            begin
              result_q    <= sc_res_d;
              result_hi_q <= sc_hi_d;
              flags_q     <= sc_flags_d;
              out_valid_q <= 1'b1;
            end
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        S_BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          result_q    <= mc_res_d;
          result_hi_q <= hi_q;
          flags_q     <= mc_flags_d;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (WIDTH=8); expectations follow
// ALU_SEQ_MULDIV_EN so the same bench covers both builds.
module tb_alu_seq_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  // Present one operation, wait (bounded) for acceptance, return #1 after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_accept: in_ready=%0b required 1 (op=%0d)", in_ready, o);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a  = W'($urandom);
    b  = W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; op = 4'd0; a = 8'd1; b = 8'd1; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0) begin
        bad++;
        $display("FAIL reset_state: out_valid=%0b result=%h flags=%b required 0/00/0000",
                 out_valid, result, flags);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_single_ops();
    logic [3:0]   t_op  [15] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd5, 4'd6, 4'd7, 4'd8,
                                 4'd9, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15};
    logic [W-1:0] t_a   [15] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h05, 8'h00, 8'h00, 8'h0F,
                                 8'hF0, 8'hF0, 8'h81, 8'h01, 8'h7F, 8'h00, 8'h80};
    logic [W-1:0] t_b   [15] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h03, 8'h55, 8'h00,
                                 8'h3C, 8'h0C, 8'h00, 8'h00, 8'h33, 8'h44, 8'h00};
    logic [W-1:0] t_res [15] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01, 8'h01, 8'hF0,
                                 8'h30, 8'hFC, 8'h02, 8'h00, 8'h80, 8'hFF, 8'h7F};
    logic [3:0]   t_flg [15] = '{4'b0011, 4'b0100, 4'b0010, 4'b0100, 4'b0001, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0011,
                                 4'b0100, 4'b0010, 4'b0100};
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      total++;
      if (out_valid !== 1'b1 || result !== t_res[i] || result_hi !== 8'h00 || flags !== t_flg[i]) begin
        bad++;
        $display("FAIL single_op[%0d] op=%0d: valid=%0b result=%h hi=%h flags=%b required 1/%h/00/%b",
                 i, t_op[i], out_valid, result, result_hi, flags, t_res[i], t_flg[i]);
      end
    end
  endtask

  task automatic test_muldiv();
`ifdef ALU_SEQ_MULDIV_EN
    logic [3:0]   t_op  [3] = '{4'd2, 4'd3, 4'd4};
    logic [W-1:0] t_a   [3] = '{8'hFF, 8'd200, 8'd200};
    logic [W-1:0] t_b   [3] = '{8'hFF, 8'd7, 8'd7};
    logic [W-1:0] t_res [3] = '{8'h01, 8'd28, 8'd4};
    logic [W-1:0] t_hi  [3] = '{8'hFE, 8'd4, 8'd4};
    logic [3:0]   t_flg [3] = '{4'b0100, 4'b0000, 4'b0000};
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL busy_in_ready[%0d] cycle %0d: in_ready=%0b required 0", i, n, in_ready);
        end
        @(posedge clk);
        #1;
        n++;
      end
      total++;
      if (n != 9) begin
        bad++;
        $display("FAIL muldiv_latency[%0d]: cycles=%0d required 9", i, n);
      end
      total++;
      if (result !== t_res[i] || result_hi !== t_hi[i] || flags !== t_flg[i] || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL muldiv_result[%0d]: result=%h hi=%h flags=%b in_ready=%0b required %h/%h/%b/1",
                 i, result, result_hi, flags, in_ready, t_res[i], t_hi[i], t_flg[i]);
      end
    end
    issue(4'd3, 8'd9, 8'd0);
    total++;
    if (out_valid !== 1'b1 || result !== 8'hFF || result_hi !== 8'd9 || flags !== 4'b1000) begin
      bad++;
      $display("FAIL div_by_zero: valid=%0b result=%h hi=%h flags=%b required 1/ff/09/1000",
               out_valid, result, result_hi, flags);
    end
`else
    logic [3:0]   t_op [4] = '{4'd2, 4'd3, 4'd4, 4'd3};
    logic [W-1:0] t_b  [4] = '{8'hFF, 8'd7, 8'd7, 8'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], 8'd200, t_b[i]);
      total++;
      if (out_valid !== 1'b1 || result !== 8'h00 || result_hi !== 8'h00 || flags !== 4'b1000) begin
        bad++;
        $display("FAIL muldiv_disabled[%0d]: valid=%0b result=%h hi=%h flags=%b required 1/00/00/1000",
                 i, out_valid, result, result_hi, flags);
      end
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa   [3] = '{8'hA5, 8'h3C, 8'h55};
    logic [W-1:0] xb   [3] = '{8'h0F, 8'hFF, 8'h55};
    logic [W-1:0] xexp [3] = '{8'hAA, 8'hC3, 8'h00};
    logic [3:0]   xflg [3] = '{4'b0000, 4'b0000, 4'b0001};
    int tx = 0;
    int rx = 0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = (c >= 4);
      if (tx < 3) begin
        in_valid = 1'b1; op = 4'd11; a = xa[tx]; b = xb[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 1 && c <= 3) begin
        total++;
        if (out_valid !== 1'b1 || result !== xexp[0] || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold cycle %0d: valid=%0b result=%h in_ready=%0b required 1/%h/0",
                   c, out_valid, result, in_ready, xexp[0]);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (rx >= 3) begin
          bad++;
          $display("FAIL xor_extra_result: result=%h required none", result);
        end else if (result !== xexp[rx] || flags !== xflg[rx]) begin
          bad++;
          $display("FAIL xor_order[%0d]: result=%h flags=%b required %h/%b",
                   rx, result, flags, xexp[rx], xflg[rx]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rx != 3 || tx != 3) begin
      bad++;
      $display("FAIL xor_count: delivered=%0d accepted=%0d required 3/3", rx, tx);
    end
  endtask

  task automatic test_reset_mid_op();
    // Reset discards a held, unconsumed result.
    out_ready = 1'b0;
    issue(4'd9, 8'hF0, 8'h3C);
    total++;
    if (out_valid !== 1'b1 || result !== 8'h30) begin
      bad++;
      $display("FAIL held_before_reset: valid=%0b result=%h required 1/30", out_valid, result);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_clears_held: valid=%0b result=%h flags=%b in_ready=%0b required 0/00/0000/1",
               out_valid, result, flags, in_ready);
    end
    out_ready = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
    issue(4'd2, 8'h12, 8'h34);
    repeat (3) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mul_early_valid: out_valid=%0b required 0", out_valid);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h00 || result_hi !== 8'h00 || flags !== 4'h0) begin
      bad++;
      $display("FAIL mid_mul_reset: valid=%0b in_ready=%0b result=%h hi=%h flags=%b required 0/1/00/00/0000",
               out_valid, in_ready, result, result_hi, flags);
    end
    repeat (12) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL aborted_op_valid: out_valid=%0b required 0", out_valid);
      end
    end
`endif
    issue(4'd0, 8'd3, 8'd4);
    total++;
    if (out_valid !== 1'b1 || result !== 8'd7 || flags !== 4'b0000) begin
      bad++;
      $display("FAIL add_after_reset: valid=%0b result=%h flags=%b required 1/07/0000",
               out_valid, result, flags);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0; out_ready = 1'b1;
    test_reset();
    test_single_ops();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
